jam_cost_server: RTL and testbench

- Responder side of the job-assignment cost interface.
- Holds the worker x job cost matrix, streamed in once after reset through a valid/ready load port.
- Once loaded, answers every (W, J) query from the assignment engine with Cost in the same cycle.
- Captures the engine's final MinCost/MatchCount when Valid asserts. Sits beside the engine in the top level and replaces the bench-side cost ROM.

---
 rtl/jam_cost_pkg.sv | 21 ++
 rtl/jam_cost_mem.sv | 35 +++
 rtl/jam_cost_server.sv | 112 +++++++++++
 tb/tb_jam_cost_server.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_cost_pkg.sv
// rtl/jam_cost_pkg.sv - shared types, default widths and derived sizes for the cost server
package jam_cost_pkg;

    localparam int IDX_W_DEF  = 3;
    localparam int COST_W_DEF = 7;
    localparam int CNT_W_DEF  = 16;

    localparam int MATRIX_N = 2 ** (2 * IDX_W_DEF);
    localparam int RES_W    = COST_W_DEF + IDX_W_DEF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int matrix_n(input int idx_w);
        return 1 << (2 * idx_w);
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - cost register file, one synchronous write port, one combinational read port
module jam_cost_mem
    import jam_cost_pkg::*;
#(
    parameter int AW = 2 * IDX_W_DEF,
    parameter int DW = COST_W_DEF
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // No reset: contents survive RST and are rewritten by the next full load.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - cost matrix responder: streamed load, same-cycle lookup, result capture
module jam_cost_server
    import jam_cost_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int COST_W = COST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load_valid,
    input  logic [COST_W-1:0]       load_data,
    output logic                    load_ready,
    output logic                    run,
    input  logic [IDX_W-1:0]        W,
    input  logic [IDX_W-1:0]        J,
    output logic [COST_W-1:0]       Cost,
    input  logic                    Valid,
    input  logic [COST_W+IDX_W-1:0] MinCost,
    input  logic [IDX_W:0]          MatchCount,
    output logic                    done,
    output logic [COST_W+IDX_W-1:0] res_min,
    output logic [IDX_W:0]          res_cnt,
    output logic [CNT_W-1:0]        q_cycles
);

    localparam int AW = 2 * IDX_W;
    localparam int N  = matrix_n(IDX_W);
    localparam int RW = COST_W + IDX_W;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [RW-1:0]     res_min_q, res_min_d;
    logic [IDX_W:0]    res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]  q_cycles_q, q_cycles_d;
    logic              load_fire;
    logic [COST_W-1:0] rd_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_min_d  = res_min_q;
        res_cnt_d  = res_cnt_q;
        q_cycles_d = q_cycles_q;
        load_fire  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    load_fire = 1'b1;
                    idx_d     = idx_q + AW'(1);
                    if (idx_q == AW'(N - 1)) begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                if (q_cycles_q != '1) begin
                    q_cycles_d = q_cycles_q + CNT_W'(1);
                end
                if (Valid) begin
                    res_min_d = MinCost;
                    res_cnt_d = MatchCount;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            res_min_q  <= '0;
            res_cnt_q  <= '0;
            q_cycles_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            res_min_q  <= res_min_d;
            res_cnt_q  <= res_cnt_d;
            q_cycles_q <= q_cycles_d;
        end
    end

    // Reset wins over a coincident beat, so the table is never touched during RST.
    jam_cost_mem #(
        .AW(AW),
        .DW(COST_W)
    ) u_mem (
        .clk    (CLK),
        .wr_en  (load_fire && !RST),
        .wr_addr(idx_q),
        .wr_data(load_data),
        .rd_addr({W, J}),
        .rd_data(rd_data)
    );

    assign load_ready = (state_q == ST_LOAD);
    assign run        = (state_q == ST_SERVE) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign Cost       = run ? rd_data : '0;
    assign res_min    = res_min_q;
    assign res_cnt    = res_cnt_q;
    assign q_cycles   = q_cycles_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - scoreboard bench for jam_cost_server
module tb_jam_cost_server;

    localparam int IW = 3;
    localparam int CW = 7;
    localparam int NW = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             load_valid = 1'b0;
    logic [CW-1:0]    load_data = '0;
    logic             load_ready;
    logic             run;
    logic [IW-1:0]    W = '0;
    logic [IW-1:0]    J = '0;
    logic [CW-1:0]    Cost;
    logic             Valid = 1'b0;
    logic [CW+IW-1:0] MinCost = '0;
    logic [IW:0]      MatchCount = '0;
    logic             done;
    logic [CW+IW-1:0] res_min;
    logic [IW:0]      res_cnt;
    logic [NW-1:0]    q_cycles;

    always #5 CLK = ~CLK;

    jam_cost_server #(.IDX_W(IW), .COST_W(CW), .CNT_W(NW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .run       (run),
        .W         (W),
        .J         (J),
        .Cost      (Cost),
        .Valid     (Valid),
        .MinCost   (MinCost),
        .MatchCount(MatchCount),
        .done      (done),
        .res_min   (res_min),
        .res_cnt   (res_cnt),
        .q_cycles  (q_cycles)
    );

    typedef enum {K_COST, K_READY, K_RUN, K_DONE, K_RESMIN, K_RESCNT, K_QCYC, K_ACC} kind_e;
    typedef struct {
        kind_e kind;
        string name;
        int    exp;
    } chk_t;

    chk_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;
    int   tab[64];

    always @(posedge CLK) begin
        if (RST) acc_cnt <= 0;
        else if (load_valid && load_ready) acc_cnt <= acc_cnt + 1;
    end

    function automatic int actual(input kind_e k);
        case (k)
            K_COST:   return int'(Cost);
            K_READY:  return int'(load_ready);
            K_RUN:    return int'(run);
            K_DONE:   return int'(done);
            K_RESMIN: return int'(res_min);
            K_RESCNT: return int'(res_cnt);
            K_QCYC:   return int'(q_cycles);
            default:  return acc_cnt;
        endcase
    endfunction

    always @(negedge CLK) begin
        while (sb.size() != 0) begin
            chk_t c;
            int   a;
            c = sb.pop_front();
            a = actual(c.kind);
            n_tests++;
            if (a != c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", c.name, a, c.exp);
            end
        end
    end

    task automatic push(input kind_e k, input string nm, input int e);
        chk_t c;
        c.kind = k;
        c.name = nm;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        load_valid = 1'b0;
        Valid = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic load_const(input int v);
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1;
            load_data  = CW'(v);
            tab[i]     = v;
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = 6'(i);
            W = a[5:3];
            J = a[2:0];
            push(K_COST, nm, tab[i]);
            tick();
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        push(K_READY, "rst_ready", 1);
        push(K_RUN, "rst_run", 0);
        push(K_DONE, "rst_done", 0);
        push(K_RESMIN, "rst_res_min", 0);
        push(K_RESCNT, "rst_res_cnt", 0);
        push(K_QCYC, "rst_q_cycles", 0);
        push(K_COST, "rst_cost", 0);

        // Back-to-back ramp load, load_valid held one extra cycle
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1;
            load_data  = CW'((i * 3) % 128);
            tab[i]     = (i * 3) % 128;
            push(K_READY, "t1_ready", 1);
            if (i == 63) push(K_RUN, "t1_run_early", 0);
            tick();
        end
        load_data = '0;
        push(K_RUN, "t1_run", 1);
        push(K_READY, "t1_ready_low", 0);
        push(K_QCYC, "t1_q_start", 0);
        tick();
        load_valid = 1'b0;
        push(K_ACC, "t1_accepts", 64);
        W = 3'd2;
        J = 3'd5;
        push(K_COST, "t1_cost_2_5", 63);
        tick();

        // Same ramp with load_valid toggling every other cycle
        do_reset();
        for (int c = 0; c < 127; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = CW'(((c / 2) * 3) % 128);
            if (c == 126) push(K_RUN, "t2_run_early", 0);
            tick();
        end
        load_valid = 1'b0;
        push(K_ACC, "t2_accepts", 64);
        push(K_RUN, "t2_run", 1);
        push(K_READY, "t2_ready_low", 0);
        push(K_QCYC, "t2_q_start", 0);
        sweep("t2_cost");
        push(K_QCYC, "t2_q_after_sweep", 64);

        // Result capture and DONE behaviour
        MinCost = 10'd412;
        MatchCount = 4'd3;
        Valid = 1'b1;
        tick();
        Valid = 1'b0;
        push(K_DONE, "t3_done", 1);
        push(K_RESMIN, "t3_res_min", 412);
        push(K_RESCNT, "t3_res_cnt", 3);
        push(K_QCYC, "t3_q_capture", 65);
        repeat (3) tick();
        push(K_QCYC, "t3_q_frozen", 65);
        MinCost = 10'd5;
        MatchCount = 4'd1;
        Valid = 1'b1;
        tick();
        Valid = 1'b0;
        push(K_RESMIN, "t3_res_min_kept", 412);
        push(K_RESCNT, "t3_res_cnt_kept", 3);
        push(K_DONE, "t3_done_held", 1);
        push(K_RUN, "t3_run_held", 1);
        W = 3'd2;
        J = 3'd5;
        push(K_COST, "t3_cost_in_done", 63);
        tick();

        // Reset mid-load, then a full reload of 9s
        do_reset();
        for (int i = 0; i < 30; i++) begin
            load_valid = 1'b1;
            load_data  = CW'(50);
            tick();
        end
        RST = 1'b1;
        load_data = CW'(77);
        tick();
        RST = 1'b0;
        load_valid = 1'b0;
        push(K_READY, "t4_ready_after_rst", 1);
        push(K_RUN, "t4_run_after_rst", 0);
        push(K_ACC, "t4_acc_after_rst", 0);
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1;
            load_data  = CW'(9);
            tab[i]     = 9;
            if (i == 10) begin
                Valid = 1'b1;
                MinCost = 10'd7;
                MatchCount = 4'd2;
                W = 3'd0;
                J = 3'd0;
                push(K_COST, "t4_cost_loading", 0);
            end
            tick();
            Valid = 1'b0;
            if (i == 10) begin
                push(K_DONE, "t4_done_ignored", 0);
                push(K_RESMIN, "t4_res_min_ignored", 0);
                push(K_RESCNT, "t4_res_cnt_ignored", 0);
                push(K_RUN, "t4_run_loading", 0);
            end
        end
        load_valid = 1'b0;
        push(K_RUN, "t4_run", 1);
        push(K_ACC, "t4_accepts", 64);
        sweep("t4_cost");
        push(K_DONE, "t4_done_still_low", 0);

        // Full-scale data and counter saturation
        do_reset();
        load_const(127);
        push(K_RUN, "t5_run", 1);
        sweep("t5_cost");
        repeat (65534 - 64) tick();
        push(K_QCYC, "t5_q_below_sat", 65534);
        tick();
        push(K_QCYC, "t5_q_sat", 65535);
        repeat (4400) tick();
        push(K_QCYC, "t5_q_hold", 65535);

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
